int_sequencer: RTL and testbench
================================

# int_sequencer

Interrupt/reset entry sequencer for the cpu6502 core. It runs the 6502 entry sequences: the reset sequence, the NMI, BRK and IRQ pushes, the vector fetch and the PC load. It drives the memory bus while `busy` is high and takes over from the DECODE FSM at instruction boundaries. It generalises the fixed single-IRQ vectoring to `N_IRQ` maskable sources, with optional per-source vectors and NMI hijack of BRK/IRQ.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `N_IRQ`, 4, number of IRQ sources
- `VECTORED`, 0: all IRQs use `VEC_IRQ`; 1: source k uses `IRQ_VEC_BASE + 2k`
- `IRQ_VEC_BASE`, 16'hFFE0, base of per-source vector table
- `STACK_PAGE`, 8'h01, stack page high byte

Ports:
- `CLK`  in  1  clock
- `RESET`  in  1  synchronous, active-high reset
- `nmi_n`  in  1  NMI, active low, falling-edge sensitive
- `irq_n`  in  N_IRQ  IRQ lines, active low, level sensitive
- `irq_en`  in  N_IRQ  per-source enable
- `i_flag`  in  1  P.I; 1 masks all IRQs
- `boundary`  in  1  DECODE strobe: current instruction complete
- `brk_req`  in  1  opcode 00 decoded, valid with `boundary`
- `pc`, `sp`, `p_in`  in  ADDR_W / 8 / 8  current PC, SP, P
- `rdata`  in  8  memory read data, valid 1 cycle after `mem_re`
- `busy`  out  1  sequencer owns bus/PC/SP
- `addr`  out  ADDR_W  memory address
- `wdata`  out  8  memory write data
- `mem_we`, `mem_re`  out  1  write / read strobes
- `sp_dec`  out  1  SP − 1 request, applied externally next cycle
- `pc_load`  out  1  load `pc_new` into PC
- `pc_new`  out  ADDR_W  vector value
- `set_i`  out  1  set P.I
- `irq_ack`  out  N_IRQ  one-hot pulse for the serviced source
- `done`  out  1  one-cycle pulse at sequence end

## Operation
- States: `RST_HOLD`, `RST_D0`, `RST_D1`, `RST_D2`, `IDLE`, `PUSH_H`, `PUSH_L`, `PUSH_P`, `VEC_LO`, `VEC_HI`, `LOAD`.
- While `RESET`=1:
  - State is `RST_HOLD`.
  - Outputs are 0, except `busy`=1 and `addr`=0.
  - NMI pending and the edge register are cleared; `nmi_prev` is set to 1.
- Reset sequence:
  - `RST_D0..D2` each assert `mem_re` at `{STACK_PAGE,sp}` plus `sp_dec`, with no writes.
  - Then `VEC_LO` with the vector `VEC_RESET`.
- NMI: a falling edge of `nmi_n` (prev=1, now=0) sets `nmi_pending`.
  - `nmi_pending` clears when `VEC_LO` is entered with the NMI vector.
  - A new edge in the same cycle as the clear keeps it set.
- IRQ request: `irq_req = |(~irq_n & irq_en) & ~i_flag`. The lowest set index wins.
- `IDLE` with `boundary`=1 selects the highest-priority source: NMI pending > `brk_req` > IRQ. If none is pending, it stays in `IDLE`.
- Pushes (each asserts `mem_we` and `sp_dec` at `addr={STACK_PAGE,sp}`):
  - `PUSH_H` writes `pc[15:8]`.
  - `PUSH_L` writes `pc[7:0]`.
  - `PUSH_P` writes `p_in | 8'h20`, with bit4 = 1 for BRK and 0 for NMI/IRQ.
- Vector selection is registered on the `PUSH_P` → `VEC_LO` transition.
  - Hijack: if NMI is pending by then, the NMI vector is used and the B bit already pushed stands.
  - The IRQ source index is also latched here, from the live request. If no request remains, the source is treated as non-vectored and no `irq_ack` is issued.
- `VEC_LO`: `mem_re` at vector. `VEC_HI`: `mem_re` at vector+1, capturing the low byte.
- `LOAD`:
  - Captures the high byte and asserts `pc_load` with `pc_new={hi,lo}`.
  - Also pulses `set_i` and `done`, plus `irq_ack` when the IRQ vector was used.
  - Returns to `IDLE` with `busy`=0.
- `VEC_NMI`=16'hFFFA, `VEC_RESET`=16'hFFFC, `VEC_IRQ`=16'hFFFE (BRK uses `VEC_IRQ` too).
- Vector+1 is computed at `ADDR_W` and wraps modulo 2^`ADDR_W`.
- `RESET` asserted in any state aborts the sequence immediately.

## Timing
- `boundary` at cycle t gives this schedule:
  - t+1 `PUSH_H`, t+2 `PUSH_L`, t+3 `PUSH_P`.
  - t+4 `VEC_LO`, t+5 `VEC_HI`, t+6 `LOAD`/`done`.
  - 7 cycles total, including the boundary cycle.
- NMI hijack window: an edge sampled up to and including cycle t+3.
- Reset: the first cycle after `RESET` falls is `RST_D0`. `LOAD` follows 5 cycles later.
- `busy` is high from t+1 through t+6. It is low in `IDLE`.
- `boundary` is ignored while `busy`=1.

## Structure
- Add to `opcodes` package:
  - `int_src_t` (`SRC_RESET`, `SRC_NMI`, `SRC_BRK`, `SRC_IRQ`)
  - `int_state_t`
  - `VEC_NMI`, `VEC_RESET`, `VEC_IRQ` constants
- Sub-module `nmi_edge_detect`: input register, falling-edge detect, and the pending flag with set-wins-over-clear.

## Test plan
- Release `RESET` with mem[FFFC]=34, mem[FFFD]=12 → 3 reads with `sp_dec`, no writes, `pc_new`=1234 and `done` 6 cycles after release.
- IRQ source 2 low, `irq_en`=4'b0100, `i_flag`=0, pc=C005, sp=FD, P=00 at `boundary` → writes 01FD=C0, 01FC=05, 01FB=20, then reads FFFE/FFFF, `irq_ack`=4'b0100.
- `VECTORED`=1, sources 1 and 3 active → source 1 serviced, vector reads at FFE2/FFE3.
- BRK at `boundary` with the NMI edge at t+2 → P pushed with bit4=1, vector reads at FFFA/FFFB, `nmi_pending` clear after t+4.
- `i_flag`=1 with all IRQs low → stays in `IDLE`; NMI edge → sequence taken; `RESET` asserted at t+3 → no further writes, `busy`=1, `RST_D0` on release.

Source files
------------

// File: rtl/int_sequencer_pkg.sv
// Shared types and fixed vectors for the 6502 interrupt/reset entry sequencer.
package opcodes;

    typedef enum logic [1:0] {
        SRC_RESET,
        SRC_NMI,
        SRC_BRK,
        SRC_IRQ
    } int_src_t;

    typedef enum logic [3:0] {
        RST_HOLD,
        RST_D0,
        RST_D1,
        RST_D2,
        IDLE,
        PUSH_H,
        PUSH_L,
        PUSH_P,
        VEC_LO,
        VEC_HI,
        LOAD
    } int_state_t;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    localparam logic [7:0] P_BIT_B = 8'h10;
    localparam logic [7:0] P_BIT_U = 8'h20;

endpackage

// File: rtl/int_sequencer_nmi_edge_detect.sv
// NMI falling-edge detector with a sticky pending flag; a fresh edge wins over a clear.
module nmi_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic nmi_n,
    input  logic clr,
    output logic pending
);

    logic r_nmi_prev;
    logic r_pending;
    logic w_fall;

    assign w_fall  = r_nmi_prev & ~nmi_n;
    assign pending = r_pending;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_nmi_prev <= 1'b1;
            r_pending  <= 1'b0;
        end else begin
            r_nmi_prev <= nmi_n;
            r_pending  <= w_fall | (r_pending & ~clr);
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/reset entry sequencer: reset, NMI, BRK and IRQ entry, vector fetch and PC load.
module int_sequencer
    import opcodes::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned N_IRQ        = 4,
    parameter bit          VECTORED     = 1'b0,
    parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0,
    parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              nmi_n,
    input  logic [N_IRQ-1:0]  irq_n,
    input  logic [N_IRQ-1:0]  irq_en,
    input  logic              i_flag,
    input  logic              boundary,
    input  logic              brk_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic [7:0]        sp,
    input  logic [7:0]        p_in,
    input  logic [7:0]        rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              sp_dec,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_new,
    output logic              set_i,
    output logic [N_IRQ-1:0]  irq_ack,
    output logic              done
);

    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    int_state_t        r_state, w_next;
    int_src_t          r_src, w_src_sel;
    logic [ADDR_W-1:0] r_vec, w_vec_sel, w_vec_tab, w_stack;
    logic [7:0]        r_lo;
    logic [IDX_W-1:0]  r_idx, w_irq_idx;
    logic              r_ack_vld, w_ack_sel, w_load_vec;
    logic              w_nmi_pending, w_nmi_clr;
    logic [N_IRQ-1:0]  w_irq_lines;
    logic              w_irq_req;
    logic [15:0]       w_pc16;
    logic [7:0]        w_p_push;

    nmi_edge_detect u_nmi (
        .CLK     (CLK),
        .RESET   (RESET),
        .nmi_n   (nmi_n),
        .clr     (w_nmi_clr),
        .pending (w_nmi_pending)
    );

    assign w_irq_lines = ~irq_n & irq_en;
    assign w_irq_req   = (|w_irq_lines) & ~i_flag;
    assign w_stack     = ADDR_W'({STACK_PAGE, sp});
    assign w_pc16      = 16'(pc);
    assign w_p_push    = ((p_in | P_BIT_U) & ~P_BIT_B) | ((r_src == SRC_BRK) ? P_BIT_B : 8'h00);
    assign w_vec_tab   = ADDR_W'(IRQ_VEC_BASE) + (ADDR_W'(w_irq_idx) << 1);
    assign w_load_vec  = (r_state == PUSH_P) || (r_state == RST_D2);

    // Lowest-numbered active source wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_irq_idx = '0;
        for (int unsigned k = N_IRQ; k > 0; k--) begin
            if (w_irq_lines[k-1]) w_irq_idx = IDX_W'(k - 1);
        end
    end

    // A pending NMI at the end of the pushes hijacks BRK/IRQ; the stacked B bit is kept.
    always_comb begin
        w_vec_sel = ADDR_W'(VEC_RESET);
        w_ack_sel = 1'b0;
        w_nmi_clr = 1'b0;
        if (r_state == PUSH_P) begin
            if (w_nmi_pending) begin
                w_vec_sel = ADDR_W'(VEC_NMI);
                w_nmi_clr = 1'b1;
            end else if (r_src == SRC_IRQ && w_irq_req) begin
                w_ack_sel = 1'b1;
                w_vec_sel = VECTORED ? w_vec_tab : ADDR_W'(VEC_IRQ);
            end else begin
                w_vec_sel = ADDR_W'(VEC_IRQ);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= RST_HOLD;
            r_src     <= SRC_RESET;
            r_vec     <= '0;
            r_lo      <= '0;
            r_idx     <= '0;
            r_ack_vld <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == PUSH_H) r_src <= w_src_sel;
            if (w_load_vec) begin
                r_vec     <= w_vec_sel;
                r_ack_vld <= w_ack_sel;
                r_idx     <= w_irq_idx;
            end
            if (r_state == VEC_HI) r_lo <= rdata;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_src_sel = SRC_IRQ;
        busy      = 1'b1;
        addr      = '0;
        wdata     = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        sp_dec    = 1'b0;
        pc_load   = 1'b0;
        pc_new    = '0;
        set_i     = 1'b0;
        irq_ack   = '0;
        done      = 1'b0;
        case (r_state)
            RST_HOLD: w_next = RST_D0;
            RST_D0, RST_D1, RST_D2: begin
                addr   = w_stack;
                mem_re = 1'b1;
                sp_dec = 1'b1;
                w_next = (r_state == RST_D0) ? RST_D1 : (r_state == RST_D1) ? RST_D2 : VEC_LO;
            end
            IDLE: begin
                busy = 1'b0;
                if (boundary) begin
                    if (w_nmi_pending) begin
                        w_src_sel = SRC_NMI;
                        w_next    = PUSH_H;
                    end else if (brk_req) begin
                        w_src_sel = SRC_BRK;
                        w_next    = PUSH_H;
                    end else if (w_irq_req) begin
                        w_src_sel = SRC_IRQ;
                        w_next    = PUSH_H;
                    end
                end
            end
            PUSH_H, PUSH_L, PUSH_P: begin
                addr   = w_stack;
                mem_we = 1'b1;
                sp_dec = 1'b1;
                wdata  = (r_state == PUSH_H) ? w_pc16[15:8] : (r_state == PUSH_L) ? w_pc16[7:0] : w_p_push;
                w_next = (r_state == PUSH_H) ? PUSH_L : (r_state == PUSH_L) ? PUSH_P : VEC_LO;
            end
            VEC_LO: begin
                addr   = r_vec;
                mem_re = 1'b1;
                w_next = VEC_HI;
            end
            VEC_HI: begin
                addr   = r_vec + ADDR_W'(1);
                mem_re = 1'b1;
                w_next = LOAD;
            end
            LOAD: begin
                pc_load = 1'b1;
                pc_new  = ADDR_W'({rdata, r_lo});
                set_i   = 1'b1;
                done    = 1'b1;
                irq_ack = r_ack_vld ? (N_IRQ'(1) << r_idx) : '0;
                w_next  = IDLE;
            end
            default: w_next = RST_HOLD;
        endcase
        if (RESET) begin
            w_next  = RST_HOLD;
            busy    = 1'b1;
            addr    = '0;
            wdata   = '0;
            mem_we  = 1'b0;
            mem_re  = 1'b0;
            sp_dec  = 1'b0;
            pc_load = 1'b0;
            pc_new  = '0;
            set_i   = 1'b0;
            irq_ack = '0;
            done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: non-vectored and vectored instances checked every cycle against a schedule model.
module tb_int_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET, nmi_n, i_flag, boundary, brk_req;
    logic [3:0]  irq_n, irq_en;
    logic [15:0] pc;
    logic [7:0]  sp, p_in, rdata0, rdata1;

    logic        busy0, we0, re0, dec0, ld0, seti0, done0;
    logic        busy1, we1, re1, dec1, ld1, seti1, done1;
    logic [15:0] addr0, addr1, pcn0, pcn1;
    logic [7:0]  wd0, wd1;
    logic [3:0]  ack0, ack1;

    int_sequencer #(.ADDR_W(16), .N_IRQ(4), .VECTORED(1'b0), .IRQ_VEC_BASE(16'hFFE0), .STACK_PAGE(8'h01)) u0 (
        .CLK(CLK), .RESET(RESET), .nmi_n(nmi_n), .irq_n(irq_n), .irq_en(irq_en), .i_flag(i_flag),
        .boundary(boundary), .brk_req(brk_req), .pc(pc), .sp(sp), .p_in(p_in), .rdata(rdata0),
        .busy(busy0), .addr(addr0), .wdata(wd0), .mem_we(we0), .mem_re(re0), .sp_dec(dec0),
        .pc_load(ld0), .pc_new(pcn0), .set_i(seti0), .irq_ack(ack0), .done(done0));

    int_sequencer #(.ADDR_W(16), .N_IRQ(4), .VECTORED(1'b1), .IRQ_VEC_BASE(16'hFFE0), .STACK_PAGE(8'h01)) u1 (
        .CLK(CLK), .RESET(RESET), .nmi_n(nmi_n), .irq_n(irq_n), .irq_en(irq_en), .i_flag(i_flag),
        .boundary(boundary), .brk_req(brk_req), .pc(pc), .sp(sp), .p_in(p_in), .rdata(rdata1),
        .busy(busy1), .addr(addr1), .wdata(wd1), .mem_we(we1), .mem_re(re1), .sp_dec(dec1),
        .pc_load(ld1), .pc_new(pcn1), .set_i(seti1), .irq_ack(ack1), .done(done1));

    logic [50:0] obs0, obs1;
    assign obs0 = {busy0, addr0, wd0, we0, re0, dec0, ld0, pcn0, seti0, ack0, done0};
    assign obs1 = {busy1, addr1, wd1, we1, re1, dec1, ld1, pcn1, seti1, ack1, done1};

    logic [7:0] mem [0:65535];
    int n_err = 0;
    int n_chk = 0;
    int n_cyc = 0;

    // Model: m_ph 0 idle, -1 held in reset, 1..6 = cycles t+1..t+6 of a sequence.
    localparam int K_RST = 0, K_NMI = 1, K_BRK = 2, K_IRQ = 3;
    int          m_ph = -1;
    int          m_kind = K_RST;
    logic [15:0] m_vec [2];
    logic [3:0]  m_ack = 4'h0;
    logic        m_nmi = 1'b0;
    logic        m_prev = 1'b1;

    // Samples of the bus taken at the falling edge.
    logic        s_we, s_re0, s_re1, s_dec, s_done, s_busy;
    logic [15:0] s_a0, s_a1;
    logic [7:0]  s_wd;
    logic [15:0] d_pcn0, d_pcn1;
    logic [3:0]  d_ack0, d_ack1;
    logic [15:0] wa_q[$], va0_q[$], va1_q[$];
    logic [7:0]  wd_q[$];
    int          n_sr, n_sdec;

    function automatic logic [50:0] expect_out(input int inst);
        logic        b, we, re, dec, ld, si, dn;
        logic [15:0] a, pn;
        logic [7:0]  wd;
        logic [3:0]  ak;
        {we, re, dec, ld, si, dn} = '0;
        a = '0; pn = '0; wd = '0; ak = '0;
        b = (m_ph != 0) || RESET;
        if (!RESET) begin
            case (m_ph)
                1, 2, 3: begin
                    a = {8'h01, sp};
                    dec = 1'b1;
                    if (m_kind == K_RST) re = 1'b1;
                    else begin
                        we = 1'b1;
                        if (m_ph == 1) wd = pc[15:8];
                        else if (m_ph == 2) wd = pc[7:0];
                        else wd = (p_in | 8'h20) & 8'hEF | ((m_kind == K_BRK) ? 8'h10 : 8'h00);
                    end
                end
                4: begin re = 1'b1; a = m_vec[inst]; end
                5: begin re = 1'b1; a = m_vec[inst] + 16'd1; end
                6: begin
                    ld = 1'b1; si = 1'b1; dn = 1'b1; ak = m_ack;
                    pn = {mem[m_vec[inst] + 16'd1], mem[m_vec[inst]]};
                end
                default: ;
            endcase
        end
        return {b, a, wd, we, re, dec, ld, pn, si, ak, dn};
    endfunction

    task automatic model_advance();
        logic fall, clr, req;
        int   k;
        fall = m_prev & ~nmi_n;
        clr  = 1'b0;
        req  = (|(~irq_n & irq_en)) & ~i_flag;
        if (RESET) begin
            m_ph = -1; m_nmi = 1'b0; m_prev = 1'b1;
            return;
        end
        case (m_ph)
            -1: begin m_ph = 1; m_kind = K_RST; end
            0: if (boundary) begin
                if (m_nmi) begin m_kind = K_NMI; m_ph = 1; end
                else if (brk_req) begin m_kind = K_BRK; m_ph = 1; end
                else if (req) begin m_kind = K_IRQ; m_ph = 1; end
            end
            3: begin
                m_ph = 4; m_ack = 4'h0;
                if (m_kind == K_RST) begin m_vec[0] = 16'hFFFC; m_vec[1] = 16'hFFFC; end
                else if (m_nmi) begin m_vec[0] = 16'hFFFA; m_vec[1] = 16'hFFFA; clr = 1'b1; end
                else if (m_kind == K_IRQ && req) begin
                    k = 0;
                    while (!(~irq_n[k] & irq_en[k])) k++;
                    m_ack = 4'h1 << k;
                    m_vec[0] = 16'hFFFE;
                    m_vec[1] = 16'hFFE0 + 16'(2 * k);
                end else begin m_vec[0] = 16'hFFFE; m_vec[1] = 16'hFFFE; end
            end
            6: m_ph = 0;
            default: m_ph = m_ph + 1;
        endcase
        m_nmi  = fall | (m_nmi & ~clr);
        m_prev = nmi_n;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        logic [50:0] e;
        @(negedge CLK);
        n_cyc++;
        for (int i = 0; i < 2; i++) begin
            e = expect_out(i);
            n_chk++;
            if (((i == 0) ? obs0 : obs1) !== e) begin
                n_err++;
                $display("FAIL bus u%0d cycle %0d: got %h want %h", i, n_cyc, (i == 0) ? obs0 : obs1, e);
            end
        end
        s_we = we0; s_re0 = re0; s_re1 = re1; s_a0 = addr0; s_a1 = addr1;
        s_wd = wd0; s_dec = dec0; s_done = done0; s_busy = busy0;
        if (s_we) begin wa_q.push_back(s_a0); wd_q.push_back(s_wd); end
        if (s_re0 && s_a0[15:8] == 8'hFF) va0_q.push_back(s_a0);
        if (s_re1 && s_a1[15:8] == 8'hFF) va1_q.push_back(s_a1);
        if (s_re0 && s_a0[15:8] == 8'h01) n_sr++;
        if (s_dec) n_sdec++;
        if (done0) begin d_pcn0 = pcn0; d_ack0 = ack0; end
        if (done1) begin d_pcn1 = pcn1; d_ack1 = ack1; end
        @(posedge CLK);
        model_advance();
        #1;
        if (s_we) mem[s_a0] = s_wd;
        rdata0 = s_re0 ? mem[s_a0] : 8'h00;
        rdata1 = s_re1 ? mem[s_a1] : 8'h00;
        if (s_dec) sp = sp - 8'd1;
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); va0_q.delete(); va1_q.delete();
        n_sr = 0; n_sdec = 0; d_pcn0 = '0; d_pcn1 = '0; d_ack0 = '0; d_ack1 = '0;
    endtask

    task automatic run_until_done(input int budget, output int cyc);
        cyc = 0;
        s_done = 1'b0;
        while (!s_done && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!s_done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
        mem[16'hFFE2] = 8'h22; mem[16'hFFE3] = 8'hA0;
        mem[16'hFFE4] = 8'h44; mem[16'hFFE5] = 8'hA4;
        RESET = 1'b1; nmi_n = 1'b1; irq_n = 4'hF; irq_en = 4'h0; i_flag = 1'b1;
        boundary = 1'b0; brk_req = 1'b0; pc = 16'h0000; sp = 8'hFD; p_in = 8'h00;
        rdata0 = 8'h00; rdata1 = 8'h00;
        clear_logs();

        // Reset held, then released: three stack reads, vector 1234, done 6 cycles later.
        repeat (3) tick();
        chk("rst_busy", 32'(s_busy), 32'd1);
        chk("rst_addr", 32'(s_a0), 32'd0);
        RESET = 1'b0;
        tick();
        run_until_done(20, cyc);
        chk("rst_latency", cyc, 6);
        chk("rst_reads", n_sr, 3);
        chk("rst_spdec", n_sdec, 3);
        chk("rst_writes", wa_q.size(), 0);
        chk("rst_pc_u0", 32'(d_pcn0), 32'h1234);
        chk("rst_pc_u1", 32'(d_pcn1), 32'h1234);

        // IRQ source 2, non-vectored and vectored.
        clear_logs();
        sp = 8'hFD; pc = 16'hC005; p_in = 8'h00;
        irq_n = 4'b1011; irq_en = 4'b0100; i_flag = 1'b0; boundary = 1'b1;
        tick();
        boundary = 1'b0;
        run_until_done(20, cyc);
        i_flag = 1'b1; irq_n = 4'hF;
        chk("irq_latency", cyc, 6);
        chk("irq_nwr", wa_q.size(), 3);
        if (wa_q.size() == 3) begin
            chk("irq_w0", {wa_q[0], 8'h00, wd_q[0]}, 32'h01FD_00C0);
            chk("irq_w1", {wa_q[1], 8'h00, wd_q[1]}, 32'h01FC_0005);
            chk("irq_w2", {wa_q[2], 8'h00, wd_q[2]}, 32'h01FB_0020);
        end
        chk("irq_vec_u0", (va0_q.size() == 2) ? {va0_q[0], va0_q[1]} : 32'h0, 32'hFFFE_FFFF);
        chk("irq_vec_u1", (va1_q.size() == 2) ? {va1_q[0], va1_q[1]} : 32'h0, 32'hFFE4_FFE5);
        chk("irq_ack_u0", 32'(d_ack0), 32'h4);
        chk("irq_pc_u0", 32'(d_pcn0), 32'h8000);
        chk("irq_pc_u1", 32'(d_pcn1), 32'hA444);

        // Sources 1 and 3 together; boundary held high through the sequence.
        clear_logs();
        sp = 8'hF8; pc = 16'h2000; p_in = 8'h01;
        irq_n = 4'b0101; irq_en = 4'b1010; i_flag = 1'b0; boundary = 1'b1;
        run_until_done(20, cyc);
        boundary = 1'b0; i_flag = 1'b1; irq_n = 4'hF;
        chk("prio_latency", cyc, 7);
        chk("prio_vec_u1", (va1_q.size() == 2) ? {va1_q[0], va1_q[1]} : 32'h0, 32'hFFE2_FFE3);
        chk("prio_vec_u0", (va0_q.size() == 2) ? {va0_q[0], va0_q[1]} : 32'h0, 32'hFFFE_FFFF);
        chk("prio_ack_u1", 32'(d_ack1), 32'h2);
        chk("prio_pc_u1", 32'(d_pcn1), 32'hA022);

        // BRK hijacked by an NMI edge landing at t+2.
        clear_logs();
        sp = 8'hF0; pc = 16'h4567; p_in = 8'hC3; brk_req = 1'b1; boundary = 1'b1;
        tick();
        boundary = 1'b0; brk_req = 1'b0;
        tick();
        nmi_n = 1'b0;
        run_until_done(20, cyc);
        chk("hij_nwr", wa_q.size(), 3);
        if (wa_q.size() == 3) chk("hij_p", {wa_q[2], 8'h00, wd_q[2]}, 32'h01EE_00F3);
        chk("hij_vec_u0", (va0_q.size() == 2) ? {va0_q[0], va0_q[1]} : 32'h0, 32'hFFFA_FFFB);
        chk("hij_ack", 32'(d_ack0), 32'h0);
        chk("hij_pc", 32'(d_pcn0), 32'h9000);
        boundary = 1'b1;
        repeat (2) tick();
        chk("hij_cleared", 32'(s_busy), 32'd0);
        boundary = 1'b0; nmi_n = 1'b1;
        tick();

        // Masked IRQs stay idle; NMI is taken; reset at t+3 aborts it.
        clear_logs();
        irq_n = 4'h0; irq_en = 4'hF; i_flag = 1'b1; boundary = 1'b1; sp = 8'hFD; pc = 16'hABCD;
        repeat (3) tick();
        chk("mask_idle", 32'(s_busy) + 32'(wa_q.size()), 32'd0);
        boundary = 1'b0; nmi_n = 1'b0;
        tick();
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        repeat (2) tick();
        chk("nmi_pushes", wa_q.size(), 2);
        RESET = 1'b1; nmi_n = 1'b1;
        clear_logs();
        tick();
        chk("abort_busy", 32'(s_busy), 32'd1);
        tick();
        RESET = 1'b0;
        tick();
        tick();
        chk("abort_d0", {29'd0, s_re0, s_dec, s_we}, 32'b110);
        run_until_done(20, cyc);
        chk("abort_writes", wa_q.size(), 0);
        chk("abort_latency", cyc, 5);
        chk("abort_pc", 32'(d_pcn0), 32'h1234);
        irq_n = 4'hF; irq_en = 4'h0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
